// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store initiator.
// Misalignment trapping is selected with DMEM_MISALIGN_TRAP_EN.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0]==11 behaves as a word access
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      f3[1]:           m = |lo;
      f3[1:0] == 2'b01: m = lo[0];
      default:         m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store mask/replication and load
// lane select with sign or zero extension.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  wmask,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic        is_b;
  logic        is_h;
  logic [7:0]  b;
  logic [15:0] h;

  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);

  always_comb begin
    b       = rd_word[{addr_lo, 3'b000} +: 8];
    h       = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    wmask   = 4'b1111;
    st_word = st_data;
    ld_data = rd_word;
    unique case (1'b1)
      is_b: begin
        wmask   = 4'b0001 << addr_lo;
        st_word = {4{st_data[7:0]}};
        ld_data = funct3[2] ? {24'b0, b}
                            : {{24{b[7]}}, b};
      end
      is_h: begin
        wmask   = 4'b0011 << {addr_lo[1], 1'b0};
        st_word = {2{st_data[15:0]}};
        ld_data = funct3[2] ? {16'b0, h}
                            : {{16{h[15]}}, h};
      end
      default: begin
        wmask   = 4'b1111;
        st_word = st_data;
        ld_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for one data-memory port.
// DMEM_MISALIGN_TRAP_EN: misaligned requests return an error response.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              mem_cen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_data
);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              acc;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wmask;
  logic [31:0]       st_word;
  logic [31:0]       ld_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign acc       = (state_q == S_ACC);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  logic mis;
  assign mis    = misaligned(req_funct3, req_addr[1:0]);
  assign addr_d = req_addr;
`else
  // Without trapping, accesses snap to natural alignment
  always_comb begin
    addr_d = req_addr;
    unique case (1'b1)
      req_funct3[1]:            addr_d[1:0] = 2'b00;
      req_funct3[1:0] == 2'b01: addr_d[0]   = 1'b0;
      default:                  addr_d      = req_addr;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= addr_d;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis) begin
              state_q <= S_RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ACC;
              err_q   <= 1'b0;
            end
`else
            state_q <= S_ACC;
`endif
          end
        end
        S_ACC: begin
          state_q <= we_q ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          rdata_q <= ld_data;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  dmem_lsu_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .st_data (wdata_q),
    .rd_word (mem_data),
    .wmask   (wmask),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = rdata_q;
  assign resp_tag   = tag_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

  // Memory pins idle at zero outside the access cycle
  assign mem_cen   = acc;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wmask = (acc && we_q) ? wmask : 4'b0;
  assign mem_wdata = (acc && we_q) ? st_word : 32'b0;

endmodule
